// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: data widths, ALU function
// codes, the controller state encoding and the divider iteration count.
package mdu_ctrl_pkg;

  localparam int W_DATA    = 32;
  localparam int W_FUNC    = 5;
  localparam int DIV_ITERS = 32;

  localparam logic [W_FUNC-1:0] FUNC_MUL = 5'd1;
  localparam logic [W_FUNC-1:0] FUNC_DIV = 5'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [W_DATA-1:0] mag(input logic [W_DATA-1:0] v,
                                            input logic              is_signed);
    return (is_signed && v[W_DATA-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Restoring shift-subtract divider on unsigned magnitudes: one quotient bit
// per cycle, DIV_ITERS cycles after start. Sign fix-up belongs to the caller.
module mdu_div
  import mdu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_kill,
  input  logic [W_DATA-1:0] i_dividend,
  input  logic [W_DATA-1:0] i_divisor,
  output logic              o_done,
  output logic [W_DATA-1:0] o_quotient,
  output logic [W_DATA-1:0] o_remainder
);

  logic              r_busy;
  logic [4:0]        r_count;
  logic [W_DATA-1:0] r_quo;
  logic [W_DATA-1:0] r_rem;
  logic [W_DATA-1:0] r_div;

  logic [W_DATA:0]   w_shift;
  logic [W_DATA:0]   w_diff;
  logic              w_fits;
  logic [W_DATA-1:0] w_next_rem;
  logic [W_DATA-1:0] w_next_quo;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in W_DATA+1 bits and the borrow bit of the difference decides.
  assign w_shift    = {r_rem, r_quo[W_DATA-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_fits     = ~w_diff[W_DATA];
  assign w_next_rem = w_fits ? w_diff[W_DATA-1:0] : w_shift[W_DATA-1:0];
  assign w_next_quo = {r_quo[W_DATA-2:0], w_fits};

  assign o_done      = r_busy && (r_count == 5'(DIV_ITERS - 1));
  assign o_quotient  = w_next_quo;
  assign o_remainder = w_next_rem;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || i_kill) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_quo   <= i_dividend;
      r_rem   <= '0;
      r_div   <= i_divisor;
    end else if (r_busy) begin
      r_quo <= w_next_quo;
      r_rem <= w_next_rem;
      if (o_done) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning the architectural HI/LO registers: stalls
// the pipeline while an iterative MUL or DIV runs and honours flush/MTHI/MTLO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_FUNC-1:0] mulalu_func,
  input  logic              mulalu_sign,
  input  logic [W_DATA-1:0] source_a,
  input  logic [W_DATA-1:0] source_b,
  input  logic              flush,
  input  logic              hi_write,
  input  logic              lo_write,
  input  logic [W_DATA-1:0] hi_write_data,
  input  logic [W_DATA-1:0] lo_write_data,
  output logic              stall,
  output logic [W_DATA-1:0] hi,
  output logic [W_DATA-1:0] lo
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_CYCLES - 1);

  mdu_state_e        r_state;
  logic [W_DATA-1:0] r_hi;
  logic [W_DATA-1:0] r_lo;
  logic [W_DATA-1:0] r_a_mag;
  logic [W_DATA-1:0] r_b_mag;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [2:0]        r_mul_cnt;

  logic              w_is_mul;
  logic              w_is_div;
  logic              w_req;
  logic [W_DATA-1:0] w_a_mag;
  logic [W_DATA-1:0] w_b_mag;
  logic              w_div_start;
  logic              w_div_done;
  logic [W_DATA-1:0] w_div_quo;
  logic [W_DATA-1:0] w_div_rem;
  logic [63:0]       w_prod_mag;
  logic [63:0]       w_prod;

  assign w_is_mul = (mulalu_func == FUNC_MUL);
  assign w_is_div = (mulalu_func == FUNC_DIV);
  assign w_req    = w_is_mul || w_is_div;
  assign w_a_mag  = mag(source_a, mulalu_sign);
  assign w_b_mag  = mag(source_b, mulalu_sign);

  assign w_div_start = (r_state == ST_IDLE) && w_is_div && !flush &&
                       (source_b != '0);

  // Product is formed from the latched magnitudes and held stable for the
  // whole MUL phase; only the final cycle's value is committed.
  assign w_prod_mag = {32'b0, r_a_mag} * {32'b0, r_b_mag};
  assign w_prod     = r_neg_q ? (~w_prod_mag + 64'd1) : w_prod_mag;

  mdu_div u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_kill      (flush),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  always_comb begin
    // NOTE: the default assignment up front covers every path, so no latch is
    // inferred for stall.
    stall = 1'b0;
    if (!rst && !flush) begin
      unique case (r_state)
        ST_IDLE: stall = w_req;
        ST_MUL:  stall = 1'b1;
        ST_DIV:  stall = 1'b1;
        ST_DONE: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_mul_cnt <= '0;
    end else if (flush) begin
      r_state   <= ST_IDLE;
      r_mul_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (hi_write) r_hi <= hi_write_data;
          if (lo_write) r_lo <= lo_write_data;
          if (w_req) begin
            r_a_mag   <= w_a_mag;
            r_b_mag   <= w_b_mag;
            r_neg_q   <= mulalu_sign && (source_a[W_DATA-1] ^ source_b[W_DATA-1]);
            r_neg_r   <= mulalu_sign && source_a[W_DATA-1];
            r_mul_cnt <= '0;
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else if (source_b == '0) begin
              r_lo    <= '1;
              r_hi    <= source_a;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (r_mul_cnt == MUL_LAST) begin
            r_hi      <= w_prod[63:32];
            r_lo      <= w_prod[31:0];
            r_mul_cnt <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_mul_cnt <= r_mul_cnt + 3'd1;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_lo    <= r_neg_q ? (~w_div_quo + 1'b1) : w_div_quo;
            r_hi    <= r_neg_r ? (~w_div_rem + 1'b1) : w_div_rem;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

`ifndef SYNTHESIS
  a_hilo_write_idle_only: assert property (
    @(posedge clk) disable iff (rst)
    (hi_write || lo_write) |-> (r_state == ST_IDLE)
  ) else $error("HI/LO write attempted outside IDLE; ignored");
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, randomized ops
// against a plain-arithmetic reference, and flush/reset/MTHI sequences.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mulalu_func;
  logic        mulalu_sign;
  logic [31:0] source_a;
  logic [31:0] source_b;
  logic        flush;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk           (clk),
    .rst           (rst),
    .mulalu_func   (mulalu_func),
    .mulalu_sign   (mulalu_sign),
    .source_a      (source_a),
    .source_b      (source_b),
    .flush         (flush),
    .hi_write      (hi_write),
    .lo_write      (lo_write),
    .hi_write_data (hi_write_data),
    .lo_write_data (lo_write_data),
    .stall         (stall),
    .hi            (hi),
    .lo            (lo)
  );

  typedef struct {
    string       name;
    logic [4:0]  func;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of MUL/DIV.
  task automatic model(input logic is_div, input logic sign, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] ehi,
                       output logic [31:0] elo, output int estall);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (sign) p = 64'(sa * sb);
      else      p = {32'b0, a} * {32'b0, b};
      ehi = p[63:32];
      elo = p[31:0];
      estall = 1 + MUL_CYCLES;
    end else if (b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
      estall = 1;
    end else begin
      if (sign) begin
        q = sa / sb;
        r = sa % sb;
        elo = q[31:0];
        ehi = r[31:0];
      end else begin
        elo = a / b;
        ehi = a % b;
      end
      estall = 33;
    end
  endtask

  task automatic idle_inputs();
    mulalu_func = 5'd0; mulalu_sign = 1'b0; source_a = '0; source_b = '0;
    flush = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    hi_write_data = '0; lo_write_data = '0;
  endtask

  // Hold a request until stall drops, counting stalled cycles, then retire it.
  task automatic run_op(input string name, input logic [4:0] func, input logic sign,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int estall);
    int n = 0;
    @(negedge clk);
    mulalu_func = func; mulalu_sign = sign; source_a = a; source_b = b;
    #1;
    while (stall === 1'b1 && n <= 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, " stall_cycles"}, 64'(n), 64'(estall));
    check({name, " hi"}, {32'b0, hi}, {32'b0, ehi});
    check({name, " lo"}, {32'b0, lo}, {32'b0, elo});
    @(negedge clk);
    mulalu_func = 5'd0;
    #1;
    check({name, " idle_after_done"}, {63'b0, stall}, 64'd0);
  endtask

  task automatic preload(input logic wr_hi, input logic [31:0] vh,
                         input logic wr_lo, input logic [31:0] vl);
    @(negedge clk);
    hi_write = wr_hi; hi_write_data = vh; lo_write = wr_lo; lo_write_data = vl;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    #1;
  endtask

  // Start an op, run n further cycles, flush in that cycle, confirm the result is dropped.
  task automatic flush_after(input string name, input logic [4:0] func,
                             input logic [31:0] a, input logic [31:0] b, input int n,
                             input logic [31:0] keep_hi, input logic [31:0] keep_lo);
    @(negedge clk);
    mulalu_func = func; mulalu_sign = 1'b0; source_a = a; source_b = b;
    for (int i = 0; i < n; i++) @(negedge clk);
    flush = 1'b1;
    #1;
    check({name, " stall_during_flush"}, {63'b0, stall}, 64'd0);
    @(negedge clk);
    flush = 1'b0; mulalu_func = 5'd0;
    #1;
    check({name, " stall_after"}, {63'b0, stall}, 64'd0);
    check({name, " hi_kept"}, {32'b0, hi}, {32'b0, keep_hi});
    check({name, " lo_kept"}, {32'b0, lo}, {32'b0, keep_lo});
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    int          est;
    logic        is_div, sgn;

    vecs[0] = '{"smul_neg",  FUNC_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3,
                32'hFFFF_FFFF, 32'hFFFF_FFFA, 1 + MUL_CYCLES};
    vecs[1] = '{"umul_max",  FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001, 1 + MUL_CYCLES};
    vecs[2] = '{"sdiv_m7_2", FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{"udiv_100_7", FUNC_DIV, 1'b0, 32'd100, 32'd7,
                32'd2, 32'd14, 33};
    vecs[4] = '{"sdiv_ovf",  FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 32'h8000_0000, 33};
    vecs[5] = '{"div_zero",  FUNC_DIV, 1'b0, 32'd5, 32'd0,
                32'd5, 32'hFFFF_FFFF, 1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", {32'b0, hi}, 64'd0);
    check("reset lo", {32'b0, lo}, 64'd0);
    check("reset stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].name, vecs[i].func, vecs[i].sign, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_stall);

    // MTHI and MTLO individually, then together.
    preload(1'b1, 32'h0000_0011, 1'b0, 32'hDEAD_BEEF);
    check("mthi hi", {32'b0, hi}, 64'h11);
    check("mthi lo_untouched", {32'b0, lo}, 64'hFFFF_FFFF);
    preload(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0022);
    check("mtlo hi_untouched", {32'b0, hi}, 64'h11);
    check("mtlo lo", {32'b0, lo}, 64'h22);

    flush_after("flush_div10", FUNC_DIV, 32'd1000, 32'd3, 10, 32'h11, 32'h22);
    model(1'b1, 1'b0, 32'd1000, 32'd3, ehi, elo, est);
    run_op("div_after_flush", FUNC_DIV, 1'b0, 32'd1000, 32'd3, ehi, elo, est);

    preload(1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002);
    check("mthilo hi", {32'b0, hi}, 64'hAAAA_0001);
    check("mthilo lo", {32'b0, lo}, 64'hBBBB_0002);
    flush_after("flush_mul_last", FUNC_MUL, 32'd3, 32'd5, MUL_CYCLES,
                32'hAAAA_0001, 32'hBBBB_0002);
    flush_after("flush_div_last", FUNC_DIV, 32'd77, 32'd5, 32,
                32'hAAAA_0001, 32'hBBBB_0002);
    flush_after("flush_start", FUNC_MUL, 32'd9, 32'd9, 0,
                32'hAAAA_0001, 32'hBBBB_0002);
    model(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd7, ehi, elo, est);
    run_op("mul_after_flush", FUNC_MUL, 1'b1, 32'hFFFF_FFF0, 32'd7, ehi, elo, est);

    // Reset in the middle of a divide.
    @(negedge clk);
    mulalu_func = FUNC_DIV; mulalu_sign = 1'b0; source_a = 32'd500; source_b = 32'd9;
    repeat (6) @(negedge clk);
    rst = 1'b1; mulalu_func = 5'd0;
    @(posedge clk);
    #1;
    check("rst_mid_div hi", {32'b0, hi}, 64'd0);
    check("rst_mid_div lo", {32'b0, lo}, 64'd0);
    check("rst_mid_div stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model(1'b1, 1'b1, 32'hFFFF_FF00, 32'd7, ehi, elo, est);
    run_op("div_after_rst", FUNC_DIV, 1'b1, 32'hFFFF_FF00, 32'd7, ehi, elo, est);

    for (int i = 0; i < 30; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      ra     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      model(is_div, sgn, ra, rb, ehi, elo, est);
      run_op($sformatf("rand%0d", i), is_div ? FUNC_DIV : FUNC_MUL, sgn, ra, rb,
             ehi, elo, est);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, the number of cycles the multiply spends in state MUL (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port mulalu_func, input, 5 bits: `FUNC_MUL or `FUNC_DIV requests an operation; 5'b00000 means none.
REQ-005 SHALL have port mulalu_sign, input, 1 bit: 1 selects signed, 0 selects unsigned.
REQ-006 SHALL have ports source_a and source_b, input, 32 bits each: a is the multiplicand/dividend, b is the multiplier/divisor.
REQ-007 SHALL have port flush, input, 1 bit: kills the instruction in EX.
REQ-008 SHALL have ports hi_write and lo_write, input, 1 bit each, plus hi_write_data and lo_write_data, input, 32 bits each: the MTHI/MTLO write path.
REQ-009 SHALL have port stall, output, 1 bit: holds the EX stage and all earlier stages.
REQ-010 SHALL have ports hi and lo, output, 32 bits each: the architectural HI/LO registers.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-012 In IDLE with mulalu_func≠0 and flush=0: SHALL latch |a|, |b|, the sign flags and the op, then move to MUL (MUL op) or DIV (DIV op, b≠0).
REQ-013 Operand magnitude is taken only when mulalu_sign=1; unsigned operands are used as-is.
REQ-014 stall SHALL be 1 in the IDLE start cycle and in every MUL/DIV cycle, and 0 in IDLE-without-request, in DONE, and whenever flush=1.
REQ-015 MUL SHALL last exactly MUL_CYCLES cycles; the 64-bit product is computed as unsigned magnitude product, then negated if the operand signs differ (signed only).
REQ-016 On leaving MUL: HI ← product[63:32], LO ← product[31:0]; then go to DONE.
REQ-017 DIV SHALL be a restoring shift-subtract divider producing one quotient bit per cycle for exactly 32 cycles.
REQ-018 On leaving DIV (signed): quotient is negated if the operand signs differ; remainder takes the dividend's sign.
REQ-019 On leaving DIV: LO ← quotient, HI ← remainder; then go to DONE.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-021 Divide by zero SHALL go IDLE→DONE directly, writing LO=0xFFFFFFFF and HI=source_a; stall is high for 1 cycle.
REQ-022 DONE SHALL last 1 cycle, then return to IDLE unconditionally; the still-present mulalu_func is not re-accepted in DONE.
REQ-023 Stall length: 1+MUL_CYCLES cycles for MUL; 33 cycles for DIV.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge, discard the in-flight result and leave HI/LO unchanged.
REQ-025 flush SHALL take priority over completion in the same cycle.
REQ-026 hi_write/lo_write SHALL update HI/LO independently, each only in IDLE; both may fire in the same cycle.
REQ-027 hi_write/lo_write outside IDLE SHALL be ignored, with a simulation assertion.

Reset
REQ-028 rst=1 SHALL force state IDLE, hi=0, lo=0, stall=0 and clear all counters and operand registers on the next edge, including mid-MUL/DIV.
REQ-029 rst SHALL take priority over flush and over any request.

Structure
REQ-030 `FUNC_MUL, `FUNC_DIV, `W_DATA and `W_FUNC SHALL come from the shared defines.vh.
REQ-031 The FSM state enum and the divide iteration count (32) SHALL live in the shared defines.vh.
REQ-032 The iterative divider SHALL be one sub-module, mdu_div (start, operand in; done, quotient, remainder out); the multiplier stays inline.

Verification
REQ-033 Signed MUL, a=0xFFFFFFFE, b=3 -> stall high for 3 cycles (MUL_CYCLES=2), then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 Unsigned MUL, 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 Signed DIV, -7/2 -> stall high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 Unsigned DIV, 100/7 -> LO=14, HI=2; then signed 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 Preload HI=0x11, LO=0x22; start DIV; flush at DIV cycle 10 -> next cycle IDLE, stall=0, HI=0x11, LO=0x22; a new request is then accepted normally.
REQ-038 Divide by zero, a=5 -> 1 stall cycle, then LO=0xFFFFFFFF, HI=5; separately, rst mid-DIV -> hi=lo=0, stall=0 the next cycle.
